if_fetch_buffer: RTL

- Stage directly downstream of the PC generator in the RV32I core.
- Consumes the fetch PC, issues in-order requests to instruction memory, and pairs each returned word with its PC.
- Buffers up to DEPTH fetched instructions and presents them to decode over a valid/ready handshake.
- Supports a single-cycle flush for redirects; responses still in flight at the flush are discarded.

---
 rtl/instructions_pkg.sv | 12 +
 rtl/if_sync_fifo.sv | 54 +++++
 rtl/if_fetch_buffer.sv | 117 +++++++++++
 3 files changed

// File: rtl/instructions_pkg.sv
// Shared RV32I fetch-path types and constants.
package instructions_pkg;

    localparam int X_LEN = 32;
    localparam logic [X_LEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [X_LEN-1:0] pc;
        logic [X_LEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_sync_fifo.sv
// Small synchronous FIFO with a one-cycle clear; used for fetch tags and fetched words.
module if_sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clear,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage is not reset; empty gates every use of the head.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    a_no_push_full: assert property (@(posedge clk) disable iff (!rstn)
        !(push && full && !pop && !clear));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rstn)
        !(pop && empty && !clear));

endmodule

// File: rtl/if_fetch_buffer.sv
// Fetch buffer: issues in-order imem requests against a credit limit, pairs responses
// with their PC and hands them to decode; flush drops buffered and in-flight fetches.
module if_fetch_buffer
    import instructions_pkg::*;
#(
    parameter int               DEPTH     = 2,
    parameter logic [X_LEN-1:0] NOP_INSTR = instructions_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [X_LEN-1:0] pc,
    input  logic             pc_valid,
    output logic             pc_ready,
    input  logic             flush,
    output logic             imem_req,
    output logic [X_LEN-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [X_LEN-1:0] imem_rdata,
    output logic             id_valid,
    output logic [X_LEN-1:0] id_instr,
    output logic [X_LEN-1:0] id_pc,
    input  logic             id_ready
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 2;

    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] tag_count;
    logic [CNT_W-1:0] fifo_count;
    logic [SUM_W-1:0] in_use;
    logic             credit;
    logic             accept;
    logic             resp_keep;
    logic             resp_drop;
    logic             id_pop;
    logic             fifo_push;
    logic [X_LEN-1:0] tag_head;
    logic             tag_full;
    logic             tag_empty;
    fetch_entry_t     fifo_in;
    fetch_entry_t     fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    // Credit uses registered occupancy only, so a pop frees a slot one cycle later.
    assign in_use = SUM_W'(outstanding) + SUM_W'(fifo_count) + SUM_W'(drop_cnt);
    assign credit = (in_use < SUM_W'(DEPTH));

    assign imem_req  = rstn & pc_valid & credit & ~flush;
    assign imem_addr = pc;
    assign pc_ready  = imem_req & imem_gnt;
    assign accept    = pc_valid & pc_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_drop = imem_rvalid & (drop_cnt != '0);
    assign resp_keep = imem_rvalid & (drop_cnt == '0) & (outstanding != '0);
    assign fifo_push = resp_keep & ~flush;
    assign id_pop    = id_valid & id_ready & ~flush;
    assign fifo_in   = '{pc: tag_head, instr: imem_rdata};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (flush) begin
            outstanding <= '0;
            drop_cnt    <= outstanding + drop_cnt - CNT_W'(resp_keep | resp_drop);
        end else begin
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(resp_keep);
            drop_cnt    <= drop_cnt - CNT_W'(resp_drop);
        end
    end

    if_sync_fifo #(.T(logic [X_LEN-1:0]), .DEPTH(DEPTH)) u_tag_q (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (flush),
        .push      (accept),
        .push_data (pc),
        .pop       (fifo_push),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    if_sync_fifo #(.T(fetch_entry_t), .DEPTH(DEPTH)) u_instr_q (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (flush),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (id_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign id_valid = ~fifo_empty;
    assign id_instr = fifo_empty ? NOP_INSTR : fifo_head.instr;
    assign id_pc    = fifo_empty ? '0 : fifo_head.pc;

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rstn)
        !(imem_rvalid && outstanding == '0 && drop_cnt == '0));
    a_credit_bound: assert property (@(posedge clk) disable iff (!rstn)
        in_use <= SUM_W'(DEPTH));
    a_tag_tracks: assert property (@(posedge clk) disable iff (!rstn)
        tag_count == outstanding);
    a_tag_room: assert property (@(posedge clk) disable iff (!rstn)
        !(accept && tag_full) && !(resp_keep && tag_empty));
    a_fifo_room: assert property (@(posedge clk) disable iff (!rstn)
        !(fifo_push && fifo_full && !id_pop));

endmodule
